// File: rtl/filter_pkg.sv
// Shared types and default geometry for the FIR tap-window feeder.
package filter_pkg;

   localparam int FILT_DATA_W = 8;
   localparam int FILT_TAPS   = 4;

   typedef logic [FILT_DATA_W-1:0]           sample_t;
   typedef logic [FILT_DATA_W*FILT_TAPS-1:0] window_t;

   typedef enum logic {PRIME, RUN} win_state_t;

endpackage

// File: rtl/filter_sample_shreg.sv
// Sample history register: newest sample in the low slice, oldest in the top slice.
module filter_sample_shreg
   import filter_pkg::*;
#(
   parameter int DATA_W = FILT_DATA_W,
   parameter int TAPS   = FILT_TAPS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     shift_en,
   input  logic [DATA_W-1:0]        in_data,
   output logic [DATA_W*TAPS-1:0]   window
);

   localparam int WIN_W = DATA_W * TAPS;

   logic [WIN_W-1:0] hist;

   assign window = hist;

   // Shifting left by one sample drops the oldest slice off the top.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         hist <= '0;
      end else if (shift_en) begin
         hist <= (hist << DATA_W) | WIN_W'(in_data);
      end
   end

endmodule

// File: rtl/filter_tap_window.sv
// Sliding sample window feeder with priming, decimation, flush and a registered valid/ready output.
module filter_tap_window
   import filter_pkg::*;
#(
   parameter int DATA_W = FILT_DATA_W,
   parameter int TAPS   = FILT_TAPS,
   parameter int DECIM  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [DATA_W*TAPS-1:0]   out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     primed
);

   localparam int WIN_W  = DATA_W * TAPS;
   localparam int FILL_W = $clog2(TAPS + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TAPS);
   localparam logic [3:0]        DECIM_CNT = 4'(DECIM);

   win_state_t         state, state_next;
   logic [FILL_W-1:0]  fill, fill_next;
   logic [3:0]         dcnt, dcnt_next, dcnt_inc;
   logic               accept, emit;
   logic [WIN_W-1:0]   window, next_window;

   assign in_ready    = !rst && !flush && (!out_valid || out_ready);
   assign accept      = in_valid && in_ready;
   assign next_window = (window << DATA_W) | WIN_W'(in_data);

   filter_sample_shreg #(
      .DATA_W (DATA_W),
      .TAPS   (TAPS)
   ) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .clear    (flush),
      .shift_en (accept),
      .in_data  (in_data),
      .window   (window)
   );

   // Priming emits on the accept that fills the history; afterwards every DECIM-th accept emits.
   always_comb begin
      state_next = state;
      fill_next  = fill;
      dcnt_next  = dcnt;
      dcnt_inc   = dcnt + 4'd1;
      emit       = 1'b0;
      if (accept) begin
         if (fill != FILL_FULL) begin
            fill_next = fill + FILL_W'(1);
         end
         case (state)
            PRIME: begin
               if (fill == FILL_FULL - FILL_W'(1)) begin
                  emit       = 1'b1;
                  dcnt_next  = '0;
                  state_next = RUN;
               end
            end
            RUN: begin
               if (dcnt_inc == DECIM_CNT) begin
                  emit      = 1'b1;
                  dcnt_next = '0;
               end else begin
                  dcnt_next = dcnt_inc;
               end
            end
            default: state_next = PRIME;
         endcase
      end
   end

   // A new window may replace one being consumed on the same edge, keeping out_valid high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PRIME;
         fill      <= '0;
         dcnt      <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         primed    <= 1'b0;
      end else if (flush) begin
         state     <= PRIME;
         fill      <= '0;
         dcnt      <= '0;
         out_valid <= 1'b0;
         primed    <= 1'b0;
      end else begin
         state  <= state_next;
         fill   <= fill_next;
         dcnt   <= dcnt_next;
         primed <= (fill_next == FILL_FULL);
         if (emit) begin
            out_data  <= next_window;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_filter_tap_window.sv
// Scoreboard bench: two instances (DECIM=1 and DECIM=2) share one stimulus stream.
module tb_filter_tap_window;

   localparam int TAPS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [7:0]  in_data = 8'h00;

   logic [31:0] od0, od1;
   logic        ov0, ov1, ir0, ir1, pr0, pr1;
   logic [31:0] od [2];
   logic        ov [2];
   logic        ir [2];
   logic        pr [2];

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q [2][$];
   logic [7:0]  hist  [2][$];
   int          acc_cnt [2];

   always #5 clk = ~clk;

   filter_tap_window #(.DATA_W(8), .TAPS(TAPS), .DECIM(1)) u0 (
      .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .primed(pr0)
   );

   filter_tap_window #(.DATA_W(8), .TAPS(TAPS), .DECIM(2)) u1 (
      .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .primed(pr1)
   );

   always_comb begin
      od[0] = od0; od[1] = od1;
      ov[0] = ov0; ov[1] = ov1;
      ir[0] = ir0; ir[1] = ir1;
      pr[0] = pr0; pr[1] = pr1;
   end

   function automatic int decim_of(input int u);
      return (u == 0) ? 1 : 2;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Offers one sample and returns just after the edge on which u0 accepted it.
   task automatic applyStimulus(input logic [7:0] d);
      int waited = 0;
      in_data  = d;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (ir0) break;
         waited++;
         if (waited > 20) begin
            checkOutput("accept_timeout", 32'(ir0), 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic resetDut();
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Reference model: history of accepted samples, emit on accept count TAPS, TAPS+DECIM, ...
   initial begin
      logic [31:0] w;
      logic        exp_ir;
      acc_cnt[0] = 0;
      acc_cnt[1] = 0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("u%0d_primed", u), 32'(pr[u]), 32'(acc_cnt[u] >= TAPS));
            checkOutput($sformatf("u%0d_out_valid", u), 32'(ov[u]), 32'(exp_q[u].size() != 0));
            exp_ir = !rst && !flush && (exp_q[u].size() == 0 || out_ready);
            checkOutput($sformatf("u%0d_in_ready", u), 32'(ir[u]), 32'(exp_ir));
            if (exp_q[u].size() != 0) begin
               checkOutput($sformatf("u%0d_out_data", u), od[u], exp_q[u][0]);
               if (out_ready) void'(exp_q[u].pop_front());
            end
            if (rst || flush) begin
               exp_q[u].delete();
               hist[u].delete();
               acc_cnt[u] = 0;
            end else if (in_valid && exp_ir) begin
               hist[u].push_front(in_data);
               if (hist[u].size() > TAPS) void'(hist[u].pop_back());
               acc_cnt[u]++;
               if (acc_cnt[u] >= TAPS && ((acc_cnt[u] - TAPS) % decim_of(u)) == 0) begin
                  w = '0;
                  for (int i = 0; i < TAPS; i++) w[i*8 +: 8] = hist[u][i];
                  exp_q[u].push_back(w);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [7:0] seq [4];
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;

      // Priming
      seq = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(seq[i]);
         if (i < 3) checkOutput("prime_no_valid", 32'(ov0), 32'd0);
      end
      checkOutput("prime_valid", 32'(ov0), 32'd1);
      checkOutput("prime_window", od0, 32'h11223344);
      checkOutput("prime_primed", 32'(pr0), 32'd1);

      applyStimulus(8'h55);
      checkOutput("steady_window", od0, 32'h22334455);

      // Backpressure with 0x66 waiting
      out_ready = 1'b0; in_data = 8'h66; in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checkOutput("bp_in_ready", 32'(ir0), 32'd0);
         checkOutput("bp_hold", od0, 32'h22334455);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      applyStimulus(8'h66);
      checkOutput("bp_release_window", od0, 32'h33445566);

      // Flush discards a pending window
      out_ready = 1'b0; flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      checkOutput("flush_clears_valid", 32'(ov0), 32'd0);
      out_ready = 1'b1;

      // Flush mid-prime
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      seq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(seq[i]);
         if (i < 3) checkOutput("flush_reprime_no_valid", 32'(ov0), 32'd0);
      end
      checkOutput("flush_reprime_window", od0, 32'hA0A1A2A3);

      // Reset mid-stream
      in_data = 8'hEE; in_valid = 1'b1; rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(ir0), 32'd0);
      @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
      checkOutput("rst_valid", 32'(ov0), 32'd0);
      checkOutput("rst_primed", 32'(pr0), 32'd0);
      seq = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
      for (int i = 0; i < 4; i++) applyStimulus(seq[i]);
      checkOutput("rst_reprime_window", od0, 32'hB0B1B2B3);

      // Decimation on the DECIM=2 instance
      resetDut();
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(8'(i));
         checkOutput($sformatf("decim_valid_%0d", i), 32'(ov1), 32'(i == 4 || i == 6 || i == 8));
         if (i == 4) checkOutput("decim_w4", od1, 32'h01020304);
         if (i == 6) checkOutput("decim_w6", od1, 32'h03040506);
         if (i == 8) checkOutput("decim_w8", od1, 32'h05060708);
      end

      // Randomised traffic, checked by the scoreboard
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 99) < 70);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 99) < 65);
         flush     = ($urandom_range(0, 99) < 2);
         rst       = ($urandom_range(0, 199) < 1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
